// File: rtl/edge_pe_task_ctrl.sv
// Edge PE task receiver: accepts one task from the RS while idle, fetches
// num_edges words from PE-local edge memory, sums them and returns a record.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   task_valid/packet     task pulse from the RS; pe_idle says one can be taken
//   mem_req/addr/gnt      edge memory read request, addr = {base, k}
//   mem_rvalid/rdata      in-order read responses
//   done_valid/ready      completion handshake with done_packet/done_sum
//   err_overrun           sticky protocol error flag
module edge_pe_task_ctrl #(
    parameter int PKT_W   = 18,
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 24,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              task_valid,
    input  logic [PKT_W-1:0]  task_packet,
    output logic              pe_idle,
    output logic              mem_req,
    output logic [14:0]       mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [PKT_W-1:0]  done_packet,
    output logic [ACC_W-1:0]  done_sum,
    output logic              err_overrun
);

    localparam int OUT_W = $clog2(MAX_OUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               pe_idle_q, pe_idle_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         issued_q, issued_d;
    logic [7:0]         rcvd_q, rcvd_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               err_q, err_d;

    logic               busy;
    logic               rx_fire;
    logic               can_issue;
    logic               grant;
    logic [7:0]         num_edges;
    logic [7:0]         new_edges;

    assign num_edges = {1'b0, pkt_q[6:0]};
    assign new_edges = {1'b0, task_packet[6:0]};
    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);

    // Responses only count while a fetch is in flight; anything arriving
    // in IDLE/DONE (e.g. stragglers from a task killed by reset) is dropped
    // silently.
    assign rx_fire   = busy && mem_rvalid && (out_q != '0);

    // A response retiring this cycle frees a slot, so a full window may
    // still issue when data comes back.
    assign can_issue = (state_q == S_FETCH)
                    && (issued_q < num_edges)
                    && ((out_q < OUT_W'(MAX_OUT)) || rx_fire);
    assign grant     = can_issue && mem_gnt;

    assign mem_req     = can_issue;
    assign mem_addr    = {pkt_q[PKT_W-1 -: 8], issued_q[6:0]};
    assign pe_idle     = pe_idle_q;
    assign done_packet = pkt_q;
    assign done_sum    = acc_q;
    assign err_overrun = err_q;

    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        err_d      = err_q;
        done_valid = 1'b0;
        issued_d   = issued_q + 8'(grant);
        rcvd_d     = rcvd_q + 8'(rx_fire);
        out_d      = out_q + OUT_W'(grant) - OUT_W'(rx_fire);
        acc_d      = rx_fire ? acc_q + ACC_W'(mem_rdata) : acc_q;

        if (task_valid && !pe_idle_q)
            err_d = 1'b1;
        if (busy && mem_rvalid && (out_q == '0))
            err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (task_valid) begin
                    pkt_d    = task_packet;
                    acc_d    = '0;
                    issued_d = '0;
                    rcvd_d   = '0;
                    out_d    = '0;
                    state_d  = (new_edges != 8'd0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (grant && (issued_q + 8'd1 == num_edges))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (rx_fire && (rcvd_q + 8'd1 == num_edges))
                    state_d = S_DONE;
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (done_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pe_idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pe_idle_q <= 1'b1;
            pkt_q     <= '0;
            acc_q     <= '0;
            issued_q  <= '0;
            rcvd_q    <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pe_idle_q <= pe_idle_d;
            pkt_q     <= pkt_d;
            acc_q     <= acc_d;
            issued_q  <= issued_d;
            rcvd_q    <= rcvd_d;
            out_q     <= out_d;
            err_q     <= err_d;
        end
    end

endmodule
